add_arbiter: RTL

Round-robin arbiter and sequencer that shares one two-operand adder between `NUM_REQ` requesters. Each requester presents an operand pair (a, b) with a valid/ready handshake. The block grants one requester at a time, issues the operands to the shared adder with a start/done handshake, and routes the sum back to the winner. It sits between the per-requester drivers and the single adder datapath. A timeout recovers the block when the adder never answers.

---
 rtl/add_arbiter_if.sv | 33 +++
 rtl/add_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/add_arbiter_if.sv
// Bundle of requester, response and adder-side signals for add_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH:0]           rsp_sum;
  logic                     rsp_err;
  logic                     add_start;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_done;
  logic [WIDTH:0]           add_sum;

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_done, add_sum,
    output req_ready, rsp_valid, rsp_sum, rsp_err,
    output add_start, add_a, add_b
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_done, add_sum,
    input  req_ready, rsp_valid, rsp_sum, rsp_err,
    input  add_start, add_a, add_b
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one two-operand adder between NUM_REQ
// requesters, with a timeout that recovers from a silent adder.
module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  add_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      id_q;
  logic [7:0]         cnt_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH:0]     rsp_sum_q;
  logic               rsp_err_q;
  logic               add_start_q;
  logic [WIDTH-1:0]   add_a_q;
  logic [WIDTH-1:0]   add_b_q;
  logic [IW-1:0]      sel_d;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset back to ptr so the nearest wins.
  always_comb begin
    sel_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(ptr_q, k)]) sel_d = rr_idx(ptr_q, k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_err_q   <= 1'b0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.req_valid) begin
            id_q        <= sel_d;
            add_a_q     <= bus.req_a[sel_d*WIDTH +: WIDTH];
            add_b_q     <= bus.req_b[sel_d*WIDTH +: WIDTH];
            add_start_q <= 1'b1;
            req_ready_q <= ONE << sel_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          add_start_q <= 1'b0;
          req_ready_q <= '0;
          cnt_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins on the timeout cycle
          if (bus.add_done) begin
            rsp_sum_q   <= bus.add_sum;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE << id_q;
            state_q     <= S_RESP;
          end else if (cnt_q == TMO) begin
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= ONE << id_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          rsp_sum_q   <= '0;
          rsp_err_q   <= 1'b0;
          ptr_q       <= (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
endmodule
